sync_fifo_wconv: RTL and testbench
==================================

// Module: sync_fifo_wconv
// PURPOSE
//  Single-clock FIFO with parametrised write-to-read width up-conversion: RATIO narrow
//  write words pack into one wide read word. Adds programmable almost-full, sticky
//  overflow/underflow, synchronous flush and a selectable show-ahead read mode.
//  Sits between narrow byte-stream producers and wider consumers in one clock domain.
// PARAMETERS
//  WR_WIDTH   8    write word width, bits
//  RATIO      2    write words per read word; RD_WIDTH = WR_WIDTH*RATIO; power of 2, >=1
//  WR_DEPTH   256  capacity in write words; power of 2, multiple of RATIO
//  AF_THRESH  240  almost_full asserts when wr_usedw >= AF_THRESH
//  SHOWAHEAD  0    0 = normal read (data 1 cycle after rd_req), 1 = head word shown early
//  MSB_FIRST  0    0 = first written word in rd_data LSBs, 1 = in MSBs
// PORTS
//  sys_clk      in   1                     clock, all logic on rising edge
//  sys_rst      in   1                     asynchronous reset, active high
//  sclr         in   1                     synchronous flush, priority over wr_req/rd_req
//  err_clr      in   1                     clears overflow/underflow
//  wr_data      in   WR_WIDTH              write data
//  wr_req       in   1                     write request
//  rd_req       in   1                     read request / acknowledge (SHOWAHEAD=1)
//  rd_data      out  RD_WIDTH              read data
//  empty        out  1                     no complete read word stored
//  full         out  1                     wr_usedw == WR_DEPTH
//  almost_full  out  1                     wr_usedw >= AF_THRESH
//  wr_usedw     out  clog2(WR_DEPTH)+1     write words held, incl. partial pack
//  rd_usedw     out  clog2(WR_DEPTH/RATIO)+1  complete read words held
//  overflow     out  1                     sticky: write attempted while full
//  underflow    out  1                     sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async) and sclr (sync): pointers, lane counter, usedw = 0; empty=1, full=0,
//    almost_full=0, overflow=underflow=0, rd_data=0; partial pack discarded.
//  - Write accepted iff wr_req && !full; data into pack lane `lane` (0..RATIO-1).
//    lane==RATIO-1: packed word committed to RAM at wr_ptr, wr_ptr++, lane=0.
//  - wr_usedw = rd_usedw*RATIO + lane; all flags registered from next-state counts.
//  - Read accepted iff rd_req && !empty; rd_ptr++, rd_usedw--, wr_usedw -= RATIO.
//  - SHOWAHEAD=0: rd_data loaded with RAM[rd_ptr] the cycle after acceptance, held otherwise.
//    SHOWAHEAD=1: rd_data = RAM[rd_ptr] whenever !empty; rd_req pops; 0 when empty.
//  - Latency: commit at edge N -> empty low, rd_usedw updated after edge N.
//  - Simultaneous accepted read+write: both take effect; counts net correctly.
//  - full: write rejected even with same-cycle read (no write-through at full).
//  - empty: read rejected even with same-cycle commit (no read-through at empty).
//  - Rejected write sets overflow; rejected read sets underflow; data/pointers untouched.
//    err_clr clears both; a same-cycle new error wins (flag stays 1).
//  - Pointers wrap modulo WR_DEPTH/RATIO; full/empty from counts, not pointer compare.
//  - RATIO=1: degenerates to plain synchronous FIFO, lane counter absent.
// STRUCTURE
//  - Shared package/header fifo_pkg: clog2 function, pack-order constants.
//  - Sub-module fifo_ram_sdp: simple dual-port RAM, RD_WIDTH x (WR_DEPTH/RATIO),
//    sync write, async read (used by both read modes).
//  - Top holds pack register, lane/pointer/usedw counters, flag logic, rd_data register.
// TESTING (defaults unless noted)
//  1 reset; write 0x11,0x22 -> empty 0 next cycle, rd_usedw=1, wr_usedw=2; rd_req ->
//    rd_data=0x2211 one cycle later (MSB_FIRST=1: 0x1122).
//  2 256 writes -> almost_full at wr_usedw=240, full at 256; 257th write -> overflow=1,
//    wr_usedw stays 256, drained data unchanged.
//  3 rd_req while empty -> underflow=1, rd_data held; err_clr -> underflow=0.
//  4 full + wr_req&rd_req same cycle -> write rejected, overflow=1, wr_usedw 256->254.
//  5 write 3 bytes then sclr -> wr_usedw=0, empty=1; partial byte never appears on read.
//  6 SHOWAHEAD=1: write 0xA1,0xB2 -> rd_data=0xB2A1 with no rd_req; rd_req -> empty=1,
//    rd_data=0; also assert sys_rst mid-burst -> all outputs to reset values at once.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and pack-order constants for the width-converting FIFO.
package fifo_pkg;

    localparam bit PACK_LSB_FIRST = 1'b0;
    localparam bit PACK_MSB_FIRST = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// fifo_ram_sdp: simple dual-port RAM, synchronous write, asynchronous read.
module fifo_ram_sdp #(
    parameter int W     = 16,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_wconv.sv
// sync_fifo_wconv: single-clock FIFO packing RATIO narrow write words into one wide read word,
// with almost-full, sticky error flags, synchronous flush and optional show-ahead reads.
module sync_fifo_wconv
    import fifo_pkg::*;
#(
    parameter int WR_WIDTH  = 8,
    parameter int RATIO     = 2,
    parameter int WR_DEPTH  = 256,
    parameter int AF_THRESH = 240,
    parameter bit SHOWAHEAD = 1'b0,
    parameter bit MSB_FIRST = PACK_LSB_FIRST,
    localparam int RD_WIDTH = WR_WIDTH * RATIO,
    localparam int RD_DEPTH = WR_DEPTH / RATIO,
    localparam int UW       = clog2(WR_DEPTH) + 1,
    localparam int RW       = clog2(RD_DEPTH) + 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                sclr,
    input  logic                err_clr,
    input  logic [WR_WIDTH-1:0] wr_data,
    input  logic                wr_req,
    input  logic                rd_req,
    output logic [RD_WIDTH-1:0] rd_data,
    output logic                empty,
    output logic                full,
    output logic                almost_full,
    output logic [UW-1:0]       wr_usedw,
    output logic [RW-1:0]       rd_usedw,
    output logic                overflow,
    output logic                underflow
);

    localparam int AW = (clog2(RD_DEPTH) > 0) ? clog2(RD_DEPTH) : 1;
    localparam int LW = (RATIO > 1) ? clog2(RATIO) : 1;

    logic [AW-1:0]       r_wr_ptr, r_rd_ptr, w_wr_ptr_nx, w_rd_ptr_nx;
    logic [LW-1:0]       r_lane, w_lane_nx, w_pos;
    logic [RW-1:0]       r_rd_usedw, w_rd_usedw_nx;
    logic [UW-1:0]       w_wr_usedw_nx;
    logic [RD_WIDTH-1:0] r_pack, w_pack_nx, w_ram_q, r_rd_data, w_rd_data_nx;
    logic                r_empty, r_full, r_af, r_ovf, r_unf, w_ovf_nx, w_unf_nx;
    logic                w_wr, w_rd, w_lane_last, w_commit;

    assign w_wr        = wr_req && !r_full;
    assign w_rd        = rd_req && !r_empty;
    assign w_lane_last = (RATIO == 1) || (r_lane == LW'(RATIO - 1));
    assign w_commit    = w_wr && w_lane_last;
    assign w_pos       = MSB_FIRST ? LW'(RATIO - 1) - r_lane : r_lane;

    // the word committed to RAM already includes the lane being written this cycle
    always_comb begin
        w_pack_nx = r_pack;
        w_pack_nx[w_pos*WR_WIDTH +: WR_WIDTH] = wr_data;
    end

    always_comb begin
        w_lane_nx     = w_wr ? (w_lane_last ? '0 : r_lane + LW'(1)) : r_lane;
        w_wr_ptr_nx   = w_commit ? (r_wr_ptr == AW'(RD_DEPTH - 1) ? '0 : r_wr_ptr + AW'(1)) : r_wr_ptr;
        w_rd_ptr_nx   = w_rd ? (r_rd_ptr == AW'(RD_DEPTH - 1) ? '0 : r_rd_ptr + AW'(1)) : r_rd_ptr;
        w_rd_usedw_nx = r_rd_usedw + RW'(w_commit) - RW'(w_rd);
        w_ovf_nx      = (r_ovf && !err_clr) || (wr_req && r_full);
        w_unf_nx      = (r_unf && !err_clr) || (rd_req && r_empty);
        w_rd_data_nx  = w_rd ? w_ram_q : r_rd_data;
        if (sclr) begin
            w_lane_nx     = '0;
            w_wr_ptr_nx   = '0;
            w_rd_ptr_nx   = '0;
            w_rd_usedw_nx = '0;
            w_ovf_nx      = 1'b0;
            w_unf_nx      = 1'b0;
            w_rd_data_nx  = '0;
        end
    end

    assign w_wr_usedw_nx = UW'(w_rd_usedw_nx) * UW'(RATIO) + UW'(w_lane_nx);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pack     <= '0;
            r_lane     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_usedw <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_af       <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_wr) r_pack <= w_pack_nx;
            r_lane     <= w_lane_nx;
            r_wr_ptr   <= w_wr_ptr_nx;
            r_rd_ptr   <= w_rd_ptr_nx;
            r_rd_usedw <= w_rd_usedw_nx;
            r_empty    <= w_rd_usedw_nx == '0;
            r_full     <= w_wr_usedw_nx == UW'(WR_DEPTH);
            r_af       <= w_wr_usedw_nx >= UW'(AF_THRESH);
            r_ovf      <= w_ovf_nx;
            r_unf      <= w_unf_nx;
            r_rd_data  <= w_rd_data_nx;
        end
    end

    fifo_ram_sdp #(
        .W     (RD_WIDTH),
        .DEPTH (RD_DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (sys_clk),
        .i_we    (w_commit && !sclr),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_pack_nx),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    assign rd_data     = SHOWAHEAD ? (r_empty ? '0 : w_ram_q) : r_rd_data;
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_af;
    assign wr_usedw    = UW'(r_rd_usedw) * UW'(RATIO) + UW'(r_lane);
    assign rd_usedw    = r_rd_usedw;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;

endmodule

// File: tb/tb_sync_fifo_wconv.sv
// tb_sync_fifo_wconv: three FIFO variants (default, MSB-first, show-ahead) on shared stimulus,
// checked every cycle against a byte-queue reference model.
module tb_sync_fifo_wconv;

    logic        clk, sys_rst, sclr, err_clr, wr_req, rd_req;
    logic [7:0]  wr_data;
    logic [15:0] rd_data [3];
    logic [8:0]  wr_usedw [3];
    logic [7:0]  rd_usedw [3];
    logic [2:0]  empty, full, af, ovf, unf;

    int          n_chk = 0;
    int          n_err = 0;
    string       ph;

    logic [7:0]  q [$];
    logic [15:0] exp_lsb, exp_msb;
    bit          m_ovf, m_unf;

    sync_fifo_wconv u_d0 (
        .sys_clk(clk), .sys_rst(sys_rst), .sclr(sclr), .err_clr(err_clr), .wr_data(wr_data),
        .wr_req(wr_req), .rd_req(rd_req), .rd_data(rd_data[0]), .empty(empty[0]), .full(full[0]),
        .almost_full(af[0]), .wr_usedw(wr_usedw[0]), .rd_usedw(rd_usedw[0]),
        .overflow(ovf[0]), .underflow(unf[0])
    );

    sync_fifo_wconv #(.MSB_FIRST(1'b1)) u_d1 (
        .sys_clk(clk), .sys_rst(sys_rst), .sclr(sclr), .err_clr(err_clr), .wr_data(wr_data),
        .wr_req(wr_req), .rd_req(rd_req), .rd_data(rd_data[1]), .empty(empty[1]), .full(full[1]),
        .almost_full(af[1]), .wr_usedw(wr_usedw[1]), .rd_usedw(rd_usedw[1]),
        .overflow(ovf[1]), .underflow(unf[1])
    );

    sync_fifo_wconv #(.SHOWAHEAD(1'b1)) u_d2 (
        .sys_clk(clk), .sys_rst(sys_rst), .sclr(sclr), .err_clr(err_clr), .wr_data(wr_data),
        .wr_req(wr_req), .rd_req(rd_req), .rd_data(rd_data[2]), .empty(empty[2]), .full(full[2]),
        .almost_full(af[2]), .wr_usedw(wr_usedw[2]), .rd_usedw(rd_usedw[2]),
        .overflow(ovf[2]), .underflow(unf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        exp_lsb = '0;
        exp_msb = '0;
    endtask

    task automatic check_all();
        int n;
        logic [15:0] sa;
        n  = q.size();
        sa = '0;
        if (n >= 2) sa = {q[1], q[0]};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.d%0d.empty", ph, k), 32'(empty[k]), 32'(n < 2));
            chk($sformatf("%s.d%0d.full", ph, k), 32'(full[k]), 32'(n == 256));
            chk($sformatf("%s.d%0d.almost_full", ph, k), 32'(af[k]), 32'(n >= 240));
            chk($sformatf("%s.d%0d.wr_usedw", ph, k), 32'(wr_usedw[k]), 32'(n));
            chk($sformatf("%s.d%0d.rd_usedw", ph, k), 32'(rd_usedw[k]), 32'(n / 2));
            chk($sformatf("%s.d%0d.overflow", ph, k), 32'(ovf[k]), 32'(m_ovf));
            chk($sformatf("%s.d%0d.underflow", ph, k), 32'(unf[k]), 32'(m_unf));
        end
        chk($sformatf("%s.d0.rd_data", ph), 32'(rd_data[0]), 32'(exp_lsb));
        chk($sformatf("%s.d1.rd_data", ph), 32'(rd_data[1]), 32'(exp_msb));
        chk($sformatf("%s.d2.rd_data", ph), 32'(rd_data[2]), 32'(sa));
    endtask

    // one clock: drive, advance past the edge, update the model, compare
    task automatic step(bit wr, logic [7:0] d, bit rd, bit sc = 1'b0, bit ec = 1'b0);
        bit f, e;
        wr_req  = wr;
        wr_data = d;
        rd_req  = rd;
        sclr    = sc;
        err_clr = ec;
        @(posedge clk);
        #1;
        if (sc) model_reset();
        else begin
            f = q.size() == 256;
            e = q.size() < 2;
            m_ovf = (m_ovf && !ec) || (wr && f);
            m_unf = (m_unf && !ec) || (rd && e);
            if (rd && !e) begin
                exp_lsb = {q[1], q[0]};
                exp_msb = {q[0], q[1]};
                void'(q.pop_front());
                void'(q.pop_front());
            end
            if (wr && !f) q.push_back(d);
        end
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        sclr    = 1'b0;
        err_clr = 1'b0;
        check_all();
    endtask

    initial begin
        sys_rst = 1'b1;
        sclr    = 1'b0;
        err_clr = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_data = '0;
        model_reset();
        #11;
        ph = "reset";
        check_all();
        #1 sys_rst = 1'b0;

        ph = "pack";
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        ph = "fill";
        repeat (256) step(1'b1, 8'($urandom), 1'b0);
        ph = "overflow";
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        ph = "full_wr_rd";
        step(1'b1, 8'h77, 1'b1);

        ph = "drain";
        repeat (127) step(1'b0, 8'h00, 1'b1);

        ph = "underflow";
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        ph = "sclr";
        repeat (3) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hC3, 1'b0);
        step(1'b1, 8'hD4, 1'b0);
        step(1'b1, 8'hE5, 1'b1, 1'b1);
        step(1'b1, 8'hC3, 1'b0);
        step(1'b1, 8'hD4, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        ph = "rand_wr";
        repeat (400) step($urandom_range(0, 99) < 75, 8'($urandom), $urandom_range(0, 99) < 30,
                          $urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0);
        ph = "rand_rd";
        repeat (400) step($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 99) < 70,
                          $urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0);

        ph = "showahead";
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        ph = "burst";
        repeat (7) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'h00, 1'b1);
        sys_rst = 1'b1;
        #1;
        model_reset();
        ph = "async_rst";
        check_all();
        #2 sys_rst = 1'b0;
        ph = "post_rst";
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h4D, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
